// File: rtl/memory_access_controller.sv
// Memory access controller: serialises one load/store/IO request at a time
// from the memory functional unit onto a fixed-latency data RAM or the byte
// IO ports, and broadcasts load/input results on the CDB.
// Optional statistics counters are built when MEM_CTRL_STAT_EN is defined;
// otherwise the stat_* ports are tied to zero.

package fcpu_pkg;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned INSTR_W  = 5;
   localparam int unsigned RSV_ID_W = 4;
   localparam int unsigned CDB_W    = RSV_ID_W + DATA_W;

   localparam logic [INSTR_W-1:0] I_NOP    = 5'h00;
   localparam logic [INSTR_W-1:0] I_ADD    = 5'h01;
   localparam logic [INSTR_W-1:0] I_LOAD   = 5'h08;
   localparam logic [INSTR_W-1:0] I_LOADB  = 5'h09;
   localparam logic [INSTR_W-1:0] I_LOADR  = 5'h0A;
   localparam logic [INSTR_W-1:0] I_STORE  = 5'h0C;
   localparam logic [INSTR_W-1:0] I_STOREB = 5'h0D;
   localparam logic [INSTR_W-1:0] I_STORER = 5'h0E;
   localparam logic [INSTR_W-1:0] I_INPUT  = 5'h10;
   localparam logic [INSTR_W-1:0] I_OUTPUT = 5'h11;
endpackage

module memory_access_controller
   import fcpu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                i_valid,
   output logic                i_ready,
   input  logic [INSTR_W-1:0]  i_opcode,
   input  logic [RSV_ID_W-1:0] i_rsv_id,
   input  logic [DATA_W-1:0]   i_address,
   input  logic [DATA_W-1:0]   i_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                io_rx_valid,
   output logic                io_rx_ready,
   input  logic [7:0]          io_rx_data,
   output logic                io_tx_valid,
   input  logic                io_tx_ready,
   output logic [7:0]          io_tx_data,
   output logic [CDB_W-1:0]    o_cdb,
   output logic                o_cdb_valid,
   input  logic                o_cdb_ready,
   output logic [31:0]         stat_loads,
   output logic [31:0]         stat_stores,
   output logic [31:0]         stat_stall
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, IO_IN, IO_OUT, RESP} state_e;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

   function automatic logic is_load(input logic [INSTR_W-1:0] op);
      return op inside {I_LOAD, I_LOADB, I_LOADR};
   endfunction

   function automatic logic is_store(input logic [INSTR_W-1:0] op);
      return op inside {I_STORE, I_STOREB, I_STORER};
   endfunction

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  op_q;
   logic [RSV_ID_W-1:0] rsv_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   res_q;
   logic [3:0]          lat_q;
   logic                rdy_q;
   logic                accept;

   // Upper address bits are intentionally ignored by the RAM.
   logic unused_addr_hi;
   assign unused_addr_hi = ^i_address[DATA_W-1:ADDR_W];

   assign accept = i_valid & i_ready;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_load(i_opcode) || is_store(i_opcode)) state_d = ISSUE;
               else if (i_opcode == I_INPUT)                state_d = IO_IN;
               else if (i_opcode == I_OUTPUT)               state_d = IO_OUT;
            end
         end
         ISSUE:  state_d = is_store(op_q) ? IDLE : WAIT;
         WAIT:   if (lat_q == 4'd0) state_d = RESP;
         IO_IN:  if (io_rx_valid)   state_d = RESP;
         IO_OUT: if (io_tx_ready)   state_d = IDLE;
         RESP:   if (o_cdb_ready)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and latched fields only.
   always_comb begin
      i_ready     = (state_q == IDLE) && rdy_q;
      mem_en      = (state_q == ISSUE);
      mem_we      = (state_q == ISSUE) && is_store(op_q);
      mem_addr    = (state_q == ISSUE) ? addr_q : '0;
      mem_wdata   = ((state_q == ISSUE) && is_store(op_q)) ? wdata_q : '0;
      io_rx_ready = (state_q == IO_IN);
      io_tx_valid = (state_q == IO_OUT);
      io_tx_data  = (state_q == IO_OUT) ? wdata_q[7:0] : '0;
      o_cdb_valid = (state_q == RESP);
      o_cdb       = (state_q == RESP) ? {rsv_q, res_q} : '0;
   end

   // Request latch, latency counter and result capture.
   // rdy_q holds i_ready low while in reset and for the release cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_q    <= '0;
         rsv_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         res_q   <= '0;
         lat_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            op_q    <= i_opcode;
            rsv_q   <= i_rsv_id;
            addr_q  <= i_address[ADDR_W-1:0];
            wdata_q <= i_data;
         end
         if (state_q == ISSUE) lat_q <= LAT_INIT;
         if (state_q == WAIT) begin
            if (lat_q == 4'd0) res_q <= mem_rdata;
            else               lat_q <= lat_q - 4'd1;
         end
         if ((state_q == IO_IN) && io_rx_valid)
            res_q <= {{(DATA_W-8){1'b0}}, io_rx_data};
      end
   end

`ifdef MEM_CTRL_STAT_EN
   logic [31:0] loads_q, stores_q, stall_q;

   // Statistics: accepted reads, accepted writes, back-pressured cycles.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         loads_q  <= '0;
         stores_q <= '0;
         stall_q  <= '0;
      end else begin
         if (accept && (is_load(i_opcode) || (i_opcode == I_INPUT)))
            loads_q <= loads_q + 32'd1;
         if (accept && (is_store(i_opcode) || (i_opcode == I_OUTPUT)))
            stores_q <= stores_q + 32'd1;
         if (i_valid && !i_ready)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_stall  = stall_q;
`else
   assign stat_loads  = '0;
   assign stat_stores = '0;
   assign stat_stall  = '0;
`endif

endmodule
